// File: rtl/spi_eeprom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_eeprom_pkg
// Description : Shared definitions for the 25xx-family SPI EEPROM sequencer:
//               instruction opcodes, the WIP status bit index and the state
//               encodings of the sequence FSM and the byte-step FSM.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package spi_eeprom_pkg;

   // 25xx instruction set subset used by the sequencer
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_WREN  = 8'h06;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] DUMMY    = 8'hFF;

   // Write-in-progress flag position inside the RDSR status byte
   localparam int unsigned WIP_BIT = 0;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WREN     = 4'd1,
      ST_CMD      = 4'd2,
      ST_ADDR_H   = 4'd3,
      ST_ADDR_L   = 4'd4,
      ST_DATA     = 4'd5,
      ST_GAP      = 4'd6,
      ST_POLL_CMD = 4'd7,
      ST_POLL_RD  = 4'd8,
      ST_DONE     = 4'd9
   } seq_state_t;

   typedef enum logic [1:0] {
      BS_IDLE    = 2'd0,
      BS_ISSUE   = 2'd1,
      BS_WAIT_LO = 2'd2,
      BS_WAIT_HI = 2'd3
   } step_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_byte_step.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_step
// Description : Runs one byte through the SPI byte engine using the
//               ISSUE -> WAIT_LO -> WAIT_HI handshake.
// Ports       : clk, rst            - clock, async active-high reset
//               go, tx, cont        - request one byte (tx / keep-CE-low flag),
//                                     sampled while idle
//               done, rx            - one-cycle completion pulse, received byte
//               sp_start            - one-cycle start pulse to the engine
//               sp_continued        - keep CE low after this byte
//               sp_txData           - byte to send (held for the whole byte)
//               sp_rxData, sp_ready - engine receive data and idle flag
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_step
   import spi_eeprom_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic [7:0] tx,
   input  logic       cont,
   output logic       done,
   output logic [7:0] rx,
   output logic       sp_start,
   output logic       sp_continued,
   output logic [7:0] sp_txData,
   input  logic [7:0] sp_rxData,
   input  logic       sp_ready
);

   step_state_t state_q, state_d;
   logic        done_q, done_d;
   logic [7:0]  rx_q, rx_d;
   logic        start_q, start_d;
   logic        cont_q, cont_d;
   logic [7:0]  tx_q, tx_d;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      start_d = 1'b0;
      rx_d    = rx_q;
      cont_d  = cont_q;
      tx_d    = tx_q;
      case (state_q)
         // tx/cont are captured here so they stay stable for the whole byte
         BS_IDLE: begin
            if (go) begin
               tx_d    = tx;
               cont_d  = cont;
               state_d = BS_ISSUE;
            end
         end
         BS_ISSUE: begin
            if (sp_ready) begin
               start_d = 1'b1;
               state_d = BS_WAIT_LO;
            end
         end
         // The engine may take a cycle to drop ready after the start pulse
         BS_WAIT_LO: begin
            if (!sp_ready) state_d = BS_WAIT_HI;
         end
         BS_WAIT_HI: begin
            if (sp_ready) begin
               rx_d    = sp_rxData;
               done_d  = 1'b1;
               state_d = BS_IDLE;
            end
         end
         default: state_d = BS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BS_IDLE;
         done_q  <= 1'b0;
         rx_q    <= 8'h00;
         start_q <= 1'b0;
         cont_q  <= 1'b0;
         tx_q    <= DUMMY;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         rx_q    <= rx_d;
         start_q <= start_d;
         cont_q  <= cont_d;
         tx_q    <= tx_d;
      end
   end

   assign done         = done_q;
   assign rx           = rx_q;
   assign sp_start     = start_q;
   assign sp_continued = cont_q;
   assign sp_txData    = tx_q;

endmodule
`default_nettype wire

// File: rtl/spi_eeprom_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_eeprom_sequencer
// Description : Expands a single-byte EEPROM read/write command into the
//               25xx byte sequence (WREN, opcode, address, data, RDSR polling)
//               and returns read data or a write-timeout error.
// Ports       : clk, rst                      - clock, async active-high reset
//               cmd_valid/cmd_ready           - command handshake
//               cmd_write, cmd_addr, cmd_wdata- command fields
//               rsp_valid, rsp_rdata, rsp_err - completion pulse and result
//               busy                          - command in progress
//               sp_start, sp_continued,
//               sp_txData, sp_rxData, sp_ready- SPI byte engine interface
// Revision    : 1.0 - initial release
// ============================================================================
module spi_eeprom_sequencer
   import spi_eeprom_pkg::*;
#(
   parameter int unsigned POLL_MAX = 255,
   parameter int unsigned POLL_GAP = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        sp_start,
   output logic        sp_continued,
   output logic [7:0]  sp_txData,
   input  logic [7:0]  sp_rxData,
   input  logic        sp_ready
);

   localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

   seq_state_t  state_q, state_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  poll_cnt_q, poll_cnt_d;
   logic [15:0] gap_cnt_q, gap_cnt_d;
   logic        launched_q, launched_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        busy_q, busy_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic        w_accept;
   logic        w_byte_state;
   logic [7:0]  w_byte_tx;
   logic        w_byte_cont;
   logic        w_step_go;
   logic        w_step_done;
   logic [7:0]  w_step_rx;
   logic [7:0]  w_poll_inc;

   // cmd_ready_q is only ever high while the FSM sits in IDLE
   assign w_accept   = cmd_valid && cmd_ready_q;
   assign w_poll_inc = (poll_cnt_q == 8'hFF) ? 8'hFF : poll_cnt_q + 8'd1;

   // Byte to send for each byte-carrying state
   always_comb begin
      w_byte_state = 1'b1;
      w_byte_tx    = DUMMY;
      w_byte_cont  = 1'b0;
      case (state_q)
         ST_WREN:     begin w_byte_tx = OP_WREN;                      w_byte_cont = 1'b0; end
         ST_CMD:      begin w_byte_tx = wr_q ? OP_WRITE : OP_READ;    w_byte_cont = 1'b1; end
         ST_ADDR_H:   begin w_byte_tx = addr_q[15:8];                 w_byte_cont = 1'b1; end
         ST_ADDR_L:   begin w_byte_tx = addr_q[7:0];                  w_byte_cont = 1'b1; end
         ST_DATA:     begin w_byte_tx = wr_q ? wdata_q : DUMMY;       w_byte_cont = 1'b0; end
         ST_POLL_CMD: begin w_byte_tx = OP_RDSR;                      w_byte_cont = 1'b1; end
         ST_POLL_RD:  begin w_byte_tx = DUMMY;                        w_byte_cont = 1'b0; end
         default:     w_byte_state = 1'b0;
      endcase
   end

   // One launch per byte state; launched_q blocks a relaunch in the done cycle
   assign w_step_go = w_byte_state && !launched_q;

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      poll_cnt_d  = poll_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      launched_d  = launched_q;
      if (w_step_go)   launched_d = 1'b1;
      if (w_step_done) launched_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               wr_d       = cmd_write;
               addr_d     = cmd_addr;
               wdata_d    = cmd_wdata;
               poll_cnt_d = 8'd0;
               state_d    = cmd_write ? ST_WREN : ST_CMD;
            end
         end
         ST_WREN:   if (w_step_done) state_d = ST_CMD;
         ST_CMD:    if (w_step_done) state_d = ST_ADDR_H;
         ST_ADDR_H: if (w_step_done) state_d = ST_ADDR_L;
         ST_ADDR_L: if (w_step_done) state_d = ST_DATA;
         ST_DATA: begin
            if (w_step_done) begin
               if (wr_q) begin
                  gap_cnt_d = 16'd0;
                  state_d   = ST_GAP;
               end else begin
                  rsp_rdata_d = w_step_rx;
                  rsp_err_d   = 1'b0;
                  state_d     = ST_DONE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = ST_POLL_CMD;
            else                       gap_cnt_d = gap_cnt_q + 16'd1;
         end
         ST_POLL_CMD: if (w_step_done) state_d = ST_POLL_RD;
         ST_POLL_RD: begin
            if (w_step_done) begin
               poll_cnt_d = w_poll_inc;
               if (!w_step_rx[WIP_BIT]) begin
                  rsp_err_d = 1'b0;
                  state_d   = ST_DONE;
               end else if ({24'd0, w_poll_inc} < POLL_MAX) begin
                  gap_cnt_d = 16'd0;
                  state_d   = ST_GAP;
               end else begin
                  rsp_err_d = 1'b1;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Status outputs are registered copies of where the FSM is heading
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      rsp_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_q        <= 1'b0;
         addr_q      <= 16'h0000;
         wdata_q     <= 8'h00;
         poll_cnt_q  <= 8'd0;
         gap_cnt_q   <= 16'd0;
         launched_q  <= 1'b0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         poll_cnt_q  <= poll_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         launched_q  <= launched_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   spi_byte_step u_step (
      .clk          (clk),
      .rst          (rst),
      .go           (w_step_go),
      .tx           (w_byte_tx),
      .cont         (w_byte_cont),
      .done         (w_step_done),
      .rx           (w_step_rx),
      .sp_start     (sp_start),
      .sp_continued (sp_continued),
      .sp_txData    (sp_txData),
      .sp_rxData    (sp_rxData),
      .sp_ready     (sp_ready)
   );

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_eeprom_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_eeprom_sequencer
// Description : Self-checking bench for spi_eeprom_sequencer. A behavioural
//               25xx EEPROM/byte-engine model answers the SPI bytes, and an
//               expectation queue of accepted commands predicts the byte
//               stream and the response of every command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_eeprom_sequencer;

   localparam int POLL_MAX = 4;
   localparam int POLL_GAP = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        sp_start;
   logic        sp_continued;
   logic [7:0]  sp_txData;
   logic [7:0]  sp_rxData;
   logic        sp_ready;

   always #5 clk = ~clk;

   spi_eeprom_sequencer #(
      .POLL_MAX (POLL_MAX),
      .POLL_GAP (POLL_GAP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_write    (cmd_write),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .busy         (busy),
      .sp_start     (sp_start),
      .sp_continued (sp_continued),
      .sp_txData    (sp_txData),
      .sp_rxData    (sp_rxData),
      .sp_ready     (sp_ready)
   );

   // A command plus how the EEPROM model will answer it
   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdval;   // byte returned for a read
      int          nwip;    // number of RDSR polls that report WIP=1
   } cmd_t;

   int          errors = 0;
   int          checks = 0;
   cmd_t        exp_q[$];
   cmd_t        next_cmd;
   logic [8:0]  tx_log[$];
   logic [8:0]  last_log[$];
   logic [7:0]  model_rdata = 8'h00;
   logic [7:0]  last_rsp_rdata;
   logic        last_rsp_err;
   int          rsp_cnt = 0;
   int          acc_cnt = 0;
   int          eng_delay = 2;

   function automatic cmd_t mk(input logic wr, input logic [15:0] addr,
                               input logic [7:0] wdata, input logic [7:0] rdval,
                               input int nwip);
      cmd_t c;
      c.wr = wr; c.addr = addr; c.wdata = wdata; c.rdval = rdval; c.nwip = nwip;
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // EEPROM + byte engine model (acts on the falling edge)
   // ---------------------------------------------------------------------
   bit         eng_busy;
   int         eng_cnt;
   int         cyc = 0;
   int         frame_pos;
   int         polls_seen;
   int         last_end_cyc;
   bit         poll_prev;
   logic [7:0] frame_op;
   logic [7:0] cur_tx;
   logic       cur_cont;
   logic [7:0] cur_rx;

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         sp_ready   = 1'b1;
         sp_rxData  = 8'h00;
         eng_busy   = 1'b0;
         eng_cnt    = 0;
         frame_pos  = 0;
         polls_seen = 0;
         poll_prev  = 1'b0;
      end else begin
         cyc++;
         if (eng_busy) begin
            chk("start_while_not_ready", {31'd0, sp_start}, 32'd0);
            chk("txdata_stable", {24'd0, sp_txData}, {24'd0, cur_tx});
            chk("continued_stable", {31'd0, sp_continued}, {31'd0, cur_cont});
            if (eng_cnt == 0) begin
               sp_ready  = 1'b1;
               sp_rxData = cur_rx;
               eng_busy  = 1'b0;
               if (cur_cont) frame_pos++;
               else begin
                  frame_pos    = 0;
                  last_end_cyc = cyc;
               end
            end else begin
               eng_cnt--;
            end
         end else if (sp_start) begin
            cur_tx   = sp_txData;
            cur_cont = sp_continued;
            tx_log.push_back({cur_cont, cur_tx});
            cur_rx   = 8'hEE;
            if (frame_pos == 0) begin
               frame_op = cur_tx;
               if (cur_tx == 8'h06) begin
                  polls_seen = 0;
                  poll_prev  = 1'b0;
               end
               if (cur_tx == 8'h05) begin
                  if (poll_prev)
                     chk("poll_gap", {31'd0, (cyc - last_end_cyc) >= POLL_GAP}, 32'd1);
                  poll_prev = 1'b1;
               end
            end else if (frame_op == 8'h03 && frame_pos == 3) begin
               cur_rx = (exp_q.size() > 0) ? exp_q[0].rdval : 8'h00;
            end else if (frame_op == 8'h05 && frame_pos == 1) begin
               cur_rx = (exp_q.size() > 0 && polls_seen < exp_q[0].nwip) ? 8'h01 : 8'h00;
               polls_seen++;
            end
            sp_ready = 1'b0;
            eng_cnt  = eng_delay;
            eng_busy = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Compare process: acceptance sampled at the edge, outputs checked 1 after
   // ---------------------------------------------------------------------
   cmd_t       acc_cmd;
   cmd_t       cur_cmd;
   bit         acc_s;
   logic [8:0] exp_b[$];
   int         npolls;
   logic [7:0] exp_rdata;
   logic       exp_err;

   always begin
      @(posedge clk);
      acc_s   = !rst && cmd_valid && cmd_ready;
      acc_cmd = next_cmd;
      #1;
      if (rst) begin
         chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
         chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_sp_start", {31'd0, sp_start}, 32'd0);
         chk("rst_sp_continued", {31'd0, sp_continued}, 32'd0);
         chk("rst_sp_txdata", {24'd0, sp_txData}, 32'hFF);
         exp_q.delete();
         tx_log.delete();
         model_rdata = 8'h00;
      end else begin
         if (acc_s) begin
            exp_q.push_back(acc_cmd);
            acc_cnt++;
         end
         chk("busy", {31'd0, busy}, {31'd0, exp_q.size() > 0});
         chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_q.size() == 0});
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
               cur_cmd = exp_q.pop_front();
               exp_b.delete();
               if (!cur_cmd.wr) begin
                  exp_b.push_back({1'b1, 8'h03});
                  exp_b.push_back({1'b1, cur_cmd.addr[15:8]});
                  exp_b.push_back({1'b1, cur_cmd.addr[7:0]});
                  exp_b.push_back({1'b0, 8'hFF});
                  exp_rdata = cur_cmd.rdval;
                  exp_err   = 1'b0;
               end else begin
                  exp_b.push_back({1'b0, 8'h06});
                  exp_b.push_back({1'b1, 8'h02});
                  exp_b.push_back({1'b1, cur_cmd.addr[15:8]});
                  exp_b.push_back({1'b1, cur_cmd.addr[7:0]});
                  exp_b.push_back({1'b0, cur_cmd.wdata});
                  npolls = (cur_cmd.nwip < POLL_MAX) ? cur_cmd.nwip + 1 : POLL_MAX;
                  for (int i = 0; i < npolls; i++) begin
                     exp_b.push_back({1'b1, 8'h05});
                     exp_b.push_back({1'b0, 8'hFF});
                  end
                  exp_rdata = model_rdata;
                  exp_err   = (cur_cmd.nwip >= POLL_MAX);
               end
               chk("byte_count", tx_log.size(), exp_b.size());
               for (int i = 0; i < exp_b.size() && i < tx_log.size(); i++)
                  chk("tx_byte", {23'd0, tx_log[i]}, {23'd0, exp_b[i]});
               chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rdata});
               chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
               model_rdata    = exp_rdata;
               last_rsp_rdata = rsp_rdata;
               last_rsp_err   = rsp_err;
               last_log       = tx_log;
               tx_log.delete();
            end
            rsp_cnt++;
         end else begin
            chk("rsp_rdata_hold", {24'd0, rsp_rdata}, {24'd0, model_rdata});
         end
      end
   end

   // ---------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------
   task automatic issue(input cmd_t c, input bit hold);
      int start = acc_cnt;
      int t = 0;
      @(negedge clk);
      next_cmd  = c;
      cmd_write = c.wr;
      cmd_addr  = c.addr;
      cmd_wdata = c.wdata;
      cmd_valid = 1'b1;
      while (acc_cnt == start && t < 6000) begin
         @(negedge clk);
         t++;
      end
      chk("accept", acc_cnt, start + 1);
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target, input int budget);
      int t = 0;
      while (rsp_cnt < target && t < budget) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      chk("rsp_count", rsp_cnt, target);
   endtask

   initial begin
      int saved;
      int t;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 16'h0000;
      cmd_wdata = 8'h00;
      next_cmd  = mk(1'b0, 16'h0000, 8'h00, 8'h00, 0);
      repeat (3) @(negedge clk);
      chk("lit_reset_txdata", {24'd0, sp_txData}, 32'hFF);
      chk("lit_reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("lit_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

      // Read 0x12A5 returning 0x3C
      issue(mk(1'b0, 16'h12A5, 8'h00, 8'h3C, 0), 1'b0);
      wait_rsp(1, 2000);
      chk("lit_read_len", last_log.size(), 4);
      if (last_log.size() == 4) begin
         chk("lit_read_b0", {23'd0, last_log[0]}, 32'h103);
         chk("lit_read_b1", {23'd0, last_log[1]}, 32'h112);
         chk("lit_read_b2", {23'd0, last_log[2]}, 32'h1A5);
         chk("lit_read_b3", {23'd0, last_log[3]}, 32'h0FF);
      end
      chk("lit_read_rdata", {24'd0, last_rsp_rdata}, 32'h3C);
      chk("lit_read_err", {31'd0, last_rsp_err}, 32'd0);

      // Write 0x5A to 0x0040, WIP reported twice then clear
      issue(mk(1'b1, 16'h0040, 8'h5A, 8'h00, 2), 1'b0);
      wait_rsp(2, 3000);
      chk("lit_write_len", last_log.size(), 11);
      if (last_log.size() == 11) begin
         chk("lit_write_b0", {23'd0, last_log[0]}, 32'h006);
         chk("lit_write_b3", {23'd0, last_log[3]}, 32'h140);
         chk("lit_write_b4", {23'd0, last_log[4]}, 32'h05A);
         chk("lit_write_b9", {23'd0, last_log[9]}, 32'h105);
      end
      chk("lit_write_err", {31'd0, last_rsp_err}, 32'd0);
      chk("lit_write_rdata_kept", {24'd0, last_rsp_rdata}, 32'h3C);

      // Write with WIP stuck: POLL_MAX polls then error
      issue(mk(1'b1, 16'h0100, 8'hA5, 8'h00, 1000), 1'b0);
      wait_rsp(3, 4000);
      chk("lit_stuck_len", last_log.size(), 13);
      chk("lit_stuck_err", {31'd0, last_rsp_err}, 32'd1);

      // Second command held pending during a read
      issue(mk(1'b0, 16'h0300, 8'h00, 8'h81, 0), 1'b1);
      issue(mk(1'b0, 16'h7E11, 8'h00, 8'h42, 0), 1'b0);
      chk("lit_second_after_first", rsp_cnt, 4);
      wait_rsp(5, 2000);
      chk("lit_second_rdata", {24'd0, last_rsp_rdata}, 32'h42);

      // Reset during the ADDR_L byte of a write
      issue(mk(1'b1, 16'h0040, 8'h11, 8'h00, 0), 1'b0);
      t = 0;
      while (tx_log.size() < 4 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("reached_addr_l", {31'd0, tx_log.size() >= 4}, 32'd1);
      saved = rsp_cnt;
      rst   = 1'b1;
      repeat (3) @(negedge clk);
      chk("lit_midrst_busy", {31'd0, busy}, 32'd0);
      chk("lit_midrst_txdata", {24'd0, sp_txData}, 32'hFF);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_rsp_after_reset", rsp_cnt, saved);
      issue(mk(1'b0, 16'hBEEF, 8'h00, 8'h77, 0), 1'b0);
      wait_rsp(saved + 1, 2000);
      chk("lit_post_reset_rdata", {24'd0, last_rsp_rdata}, 32'h77);

      // Slow engine: 50 extra cycles per byte
      eng_delay = 50;
      issue(mk(1'b0, 16'h00FF, 8'h00, 8'hC3, 0), 1'b0);
      wait_rsp(saved + 2, 3000);
      issue(mk(1'b1, 16'h2222, 8'h99, 8'h00, 1), 1'b0);
      wait_rsp(saved + 3, 6000);
      chk("lit_slow_write_len", last_log.size(), 9);
      eng_delay = 2;

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
